// File: rtl/lfu_access_arbiter.sv
// Front-end arbiter for the four-slot LFU tracker: synchronizes button presses,
// latches them as pending requests and grants them round-robin over valid/ready.
module lfu_access_arbiter #(
  parameter int unsigned HOLDOFF_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b1,
  input  logic       b2,
  input  logic       b3,
  input  logic       b4,
  input  logic       tick,
  input  logic       acc_ready,
  output logic       acc_valid,
  output logic [1:0] acc_idx,
  output logic [3:0] pending,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam logic [3:0] HoldInit = 4'(HOLDOFF_TICKS);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF} state_e;

  state_e     state_q;
  logic [3:0] s1_q, s2_q, s3_q;
  logic [3:0] pending_q, pending_d;
  logic [3:0] edgeDet, clrMask, dropMask, rot;
  logic [1:0] ptr_q, idx_q, offset, winner;
  logic [3:0] holdCnt_q;
  logic [7:0] drop_q, drop_d;
  logic [2:0] dropInc;
  logic [8:0] dropSum;
  logic       valid_q, busy_q, handshake;

  assign edgeDet   = s2_q & ~s3_q;
  assign handshake = valid_q & acc_ready;

  always_comb begin
    clrMask = 4'b0000;
    if (handshake) clrMask[idx_q] = 1'b1;
  end

  // A press that coincides with its own slot's handshake re-arms the slot
  // instead of being dropped.
  assign dropMask  = edgeDet & pending_q & ~clrMask;
  assign pending_d = (pending_q & ~clrMask) | edgeDet;
  assign dropInc   = {2'b00, dropMask[0]} + {2'b00, dropMask[1]}
                   + {2'b00, dropMask[2]} + {2'b00, dropMask[3]};
  assign dropSum   = {1'b0, drop_q} + {6'b000000, dropInc};
  assign drop_d    = dropSum[8] ? 8'hFF : dropSum[7:0];

  // Rotate pending so bit 0 is the slot at ptr; first set bit wins.
  always_comb begin
    rot = pending_q;
    unique case (ptr_q)
      2'd0: rot = pending_q;
      2'd1: rot = {pending_q[0],   pending_q[3:1]};
      2'd2: rot = {pending_q[1:0], pending_q[3:2]};
      2'd3: rot = {pending_q[2:0], pending_q[3]};
      default: rot = pending_q;
    endcase
    if (rot[0])      offset = 2'd0;
    else if (rot[1]) offset = 2'd1;
    else if (rot[2]) offset = 2'd2;
    else             offset = 2'd3;
    winner = ptr_q + offset;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= 4'b0000;
      s2_q      <= 4'b0000;
      s3_q      <= 4'b0000;
      pending_q <= 4'b0000;
      drop_q    <= 8'h00;
    end else begin
      s1_q      <= {b4, b3, b2, b1};
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      idx_q     <= 2'd0;
      ptr_q     <= 2'd0;
      holdCnt_q <= 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|pending_q) begin
            idx_q   <= winner;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (acc_ready) begin
            valid_q <= 1'b0;
            ptr_q   <= idx_q + 2'd1;
            if (HoldInit == 4'd0) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              holdCnt_q <= HoldInit;
              state_q   <= HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          if (tick) begin
            holdCnt_q <= holdCnt_q - 4'd1;
            if (holdCnt_q == 4'd1) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign acc_valid = valid_q;
  assign acc_idx   = idx_q;
  assign pending   = pending_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_lfu_access_arbiter.sv
// Bench for lfu_access_arbiter: directed scenarios plus a randomized run checked
// against a slot-level reference model, on instances with hold-off 0 and 2.
module tb_lfu_access_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       b1, b2, b3, b4, tick, accReady;
  logic       v0, v2, bz0, bz2;
  logic [1:0] i0, i2;
  logic [3:0] p0, p2;
  logic [7:0] d0, d2;

  int checks   = 0;
  int failures = 0;

  // Reference model state, index 0 -> hold-off 0 instance, 1 -> hold-off 2.
  int         holdCfg[2] = '{0, 2};
  logic [3:0] mS1[2], mS2[2], mS3[2], mPend[2];
  int         mPtr[2], mSlot[2], mWait[2], mDrop[2];
  bit         mFlight[2];

  always #5 clk = ~clk;

  lfu_access_arbiter #(.HOLDOFF_TICKS(0)) dut0 (
    .clk(clk), .rst(rst), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .tick(tick),
    .acc_ready(accReady), .acc_valid(v0), .acc_idx(i0), .pending(p0),
    .busy(bz0), .drop_cnt(d0)
  );

  lfu_access_arbiter #(.HOLDOFF_TICKS(2)) dut2 (
    .clk(clk), .rst(rst), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .tick(tick),
    .acc_ready(accReady), .acc_valid(v2), .acc_idx(i2), .pending(p2),
    .busy(bz2), .drop_cnt(d2)
  );

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mS1[k] = 4'b0; mS2[k] = 4'b0; mS3[k] = 4'b0; mPend[k] = 4'b0;
      mPtr[k] = 0; mSlot[k] = 0; mWait[k] = 0; mDrop[k] = 0; mFlight[k] = 1'b0;
    end
  endtask

  // One clock of the slot-level behaviour, using the inputs seen before the edge.
  task automatic modelStep();
    logic [3:0] raw, pressed, served, nextPend;
    int         lost, s;
    bit         found;
    raw = {b4, b3, b2, b1};
    for (int k = 0; k < 2; k++) begin
      pressed = mS2[k] & ~mS3[k];
      served  = 4'b0;
      if (mFlight[k] && accReady) served[mSlot[k]] = 1'b1;
      lost = 0;
      for (int i = 0; i < 4; i++)
        if (pressed[i] && mPend[k][i] && !served[i]) lost++;
      mDrop[k] = (mDrop[k] + lost > 255) ? 255 : mDrop[k] + lost;
      nextPend = (mPend[k] & ~served) | pressed;
      if (mFlight[k]) begin
        if (accReady) begin
          mPtr[k]    = (mSlot[k] + 1) % 4;
          mFlight[k] = 1'b0;
          mWait[k]   = holdCfg[k];
        end
      end else if (mWait[k] > 0) begin
        if (tick) mWait[k]--;
      end else if (mPend[k] != 4'b0) begin
        found = 1'b0;
        for (int j = 0; j < 4; j++) begin
          s = (mPtr[k] + j) % 4;
          if (!found && mPend[k][s]) begin
            mSlot[k] = s;
            found    = 1'b1;
          end
        end
        mFlight[k] = found;
      end
      mPend[k] = nextPend;
      mS3[k] = mS2[k]; mS2[k] = mS1[k]; mS1[k] = raw;
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    if (rst) modelStep();
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    b1 = 1'b0; b2 = 1'b0; b3 = 1'b0; b4 = 1'b0; tick = 1'b0; accReady = 1'b0;
    modelReset();
    stepCycle();
    stepCycle();
    rst = 1'b1;
  endtask

  task automatic collectGrants(input int budget, output int order[4],
                               output int gap[4], output int total);
    int lastCyc;
    lastCyc = 0;
    total   = 0;
    for (int c = 0; c < budget; c++) begin
      stepCycle();
      if (v0 === 1'b1) begin
        if (total < 4) begin
          order[total] = int'(i0);
          gap[total]   = c - lastCyc;
        end
        lastCyc = c;
        total++;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (v0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", v0); end
    checks++; if (p0 !== 4'b0) begin failures++; $display("[TB] FAIL reset_pending: got %b want 0000", p0); end
    checks++; if (d0 !== 8'd0) begin failures++; $display("[TB] FAIL reset_drop: got %0d want 0", d0); end
    checks++; if (bz2 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", bz2); end
    b1 = 1'b1; b2 = 1'b1;
    stepCycle();
    stepCycle();
    stepCycle();
    checks++; if (p2 !== 4'b0) begin failures++; $display("[TB] FAIL reset_hold_pending: got %b want 0000", p2); end
    b1 = 1'b0; b2 = 1'b0;
  endtask

  task automatic test_single_press();
    doReset();
    accReady = 1'b1;
    b3 = 1'b1;
    stepCycle();
    stepCycle();
    checks++; if (p0 !== 4'b0000) begin failures++; $display("[TB] FAIL single_e2_pending: got %b want 0000", p0); end
    stepCycle();
    checks++; if (p0 !== 4'b0100) begin failures++; $display("[TB] FAIL single_e3_pending: got %b want 0100", p0); end
    checks++; if (v0 !== 1'b0) begin failures++; $display("[TB] FAIL single_e3_valid: got %b want 0", v0); end
    stepCycle();
    checks++; if (v0 !== 1'b1) begin failures++; $display("[TB] FAIL single_e4_valid: got %b want 1", v0); end
    checks++; if (i0 !== 2'd2) begin failures++; $display("[TB] FAIL single_e4_idx: got %0d want 2", i0); end
    stepCycle();
    b3 = 1'b0;
    checks++; if (p0 !== 4'b0000) begin failures++; $display("[TB] FAIL single_e5_pending: got %b want 0000", p0); end
    checks++; if (v0 !== 1'b0) begin failures++; $display("[TB] FAIL single_e5_valid: got %b want 0", v0); end
    checks++; if (bz2 !== 1'b1) begin failures++; $display("[TB] FAIL single_holdoff_busy: got %b want 1", bz2); end
    checks++; if (bz0 !== 1'b0) begin failures++; $display("[TB] FAIL single_nohold_busy: got %b want 0", bz0); end
  endtask

  task automatic test_round_robin();
    int order[4], gap[4], total;
    int expA[4] = '{0, 1, 2, 3};
    int expB[4] = '{2, 3, 0, 1};
    doReset();
    accReady = 1'b1;
    b1 = 1'b1; b2 = 1'b1; b3 = 1'b1; b4 = 1'b1;
    collectGrants(20, order, gap, total);
    b1 = 1'b0; b2 = 1'b0; b3 = 1'b0; b4 = 1'b0;
    checks++; if (total != 4) begin failures++; $display("[TB] FAIL rr_count: got %0d want 4", total); end
    for (int i = 0; i < 4 && i < total; i++) begin
      checks++; if (order[i] != expA[i]) begin failures++; $display("[TB] FAIL rr_order_a[%0d]: got %0d want %0d", i, order[i], expA[i]); end
      if (i > 0) begin
        checks++; if (gap[i] != 2) begin failures++; $display("[TB] FAIL rr_gap[%0d]: got %0d want 2", i, gap[i]); end
      end
    end
    doReset();
    accReady = 1'b1;
    b2 = 1'b1;
    for (int c = 0; c < 8; c++) stepCycle();
    b2 = 1'b0;
    stepCycle();
    stepCycle();
    b1 = 1'b1; b2 = 1'b1; b3 = 1'b1; b4 = 1'b1;
    collectGrants(20, order, gap, total);
    b1 = 1'b0; b2 = 1'b0; b3 = 1'b0; b4 = 1'b0;
    checks++; if (total != 4) begin failures++; $display("[TB] FAIL rr_count_b: got %0d want 4", total); end
    for (int i = 0; i < 4 && i < total; i++) begin
      checks++; if (order[i] != expB[i]) begin failures++; $display("[TB] FAIL rr_order_b[%0d]: got %0d want %0d", i, order[i], expB[i]); end
    end
  endtask

  task automatic test_backpressure();
    doReset();
    accReady = 1'b0;
    b1 = 1'b1;
    for (int c = 0; c < 10 && v0 !== 1'b1; c++) stepCycle();
    checks++; if (v0 !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid_rise: got %b want 1", v0); end
    b1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      b2 = (c >= 2 && c < 5);
      stepCycle();
      checks++; if (v0 !== 1'b1 || i0 !== 2'd0) begin failures++; $display("[TB] FAIL bp_hold[%0d]: got valid=%b idx=%0d want valid=1 idx=0", c, v0, i0); end
    end
    checks++; if (p0 !== 4'b0011) begin failures++; $display("[TB] FAIL bp_pending: got %b want 0011", p0); end
    accReady = 1'b1;
    stepCycle();
    accReady = 1'b0;
    checks++; if (v0 !== 1'b0 || p0 !== 4'b0010) begin failures++; $display("[TB] FAIL bp_release: got valid=%b pending=%b want valid=0 pending=0010", v0, p0); end
  endtask

  task automatic test_holdoff();
    int  hsEdge, ticksAfter, t2Edge, secondRise;
    bit  gapOk;
    doReset();
    accReady = 1'b1;
    b1 = 1'b1; b2 = 1'b1;
    hsEdge = -1; ticksAfter = 0; t2Edge = -1; secondRise = -1; gapOk = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick = (c % 8 == 0);
      stepCycle();
      if (tick && hsEdge >= 0 && c > hsEdge) begin
        ticksAfter++;
        if (ticksAfter == 2) t2Edge = c;
      end
      if (v2 === 1'b1 && hsEdge < 0) hsEdge = c + 1;
      else if (v2 === 1'b1 && hsEdge >= 0 && secondRise < 0 && c > hsEdge) secondRise = c;
      if (hsEdge >= 0 && c >= hsEdge && (t2Edge < 0 || c < t2Edge) &&
          (bz2 !== 1'b1 || v2 !== 1'b0)) gapOk = 1'b0;
    end
    tick = 1'b0; b1 = 1'b0; b2 = 1'b0;
    checks++; if (hsEdge != 5) begin failures++; $display("[TB] FAIL hold_first_hs: got %0d want 5", hsEdge); end
    checks++; if (secondRise != 17 || secondRise != t2Edge + 1) begin failures++; $display("[TB] FAIL hold_second_rise: got %0d want 17 (tick2 at %0d)", secondRise, t2Edge); end
    checks++; if (!gapOk) begin failures++; $display("[TB] FAIL hold_busy_gap: got busy/valid wrong in gap want busy=1 valid=0"); end
  endtask

  task automatic test_drops();
    doReset();
    accReady = 1'b0;
    for (int p = 1; p <= 300; p++) begin
      b4 = 1'b1; stepCycle(); stepCycle();
      b4 = 1'b0; stepCycle(); stepCycle();
      if (p == 100) begin
        checks++; if (d0 !== 8'd99) begin failures++; $display("[TB] FAIL drop_mid: got %0d want 99", d0); end
      end
    end
    checks++; if (d0 !== 8'd255 || d2 !== 8'd255) begin failures++; $display("[TB] FAIL drop_sat: got %0d/%0d want 255", d0, d2); end
    checks++; if (p0 !== 4'b1000 || v0 !== 1'b1 || i0 !== 2'd3) begin failures++; $display("[TB] FAIL drop_state: got pend=%b valid=%b idx=%0d want 1000/1/3", p0, v0, i0); end
    for (int p = 0; p < 3; p++) begin
      b4 = 1'b1; stepCycle(); stepCycle();
      b4 = 1'b0; stepCycle(); stepCycle();
    end
    checks++; if (d0 !== 8'd255) begin failures++; $display("[TB] FAIL drop_stay: got %0d want 255", d0); end
  endtask

  task automatic test_press_on_handshake();
    doReset();
    accReady = 1'b0;
    b4 = 1'b1; stepCycle(); stepCycle();
    b4 = 1'b0;
    for (int c = 0; c < 10 && v0 !== 1'b1; c++) stepCycle();
    stepCycle(); stepCycle(); stepCycle();
    checks++; if (v0 !== 1'b1 || p0 !== 4'b1000) begin failures++; $display("[TB] FAIL hs_press_setup: got valid=%b pend=%b want 1/1000", v0, p0); end
    b4 = 1'b1;
    stepCycle();
    stepCycle();
    accReady = 1'b1;
    stepCycle();
    accReady = 1'b0;
    b4 = 1'b0;
    checks++; if (p0 !== 4'b1000 || p2 !== 4'b1000) begin failures++; $display("[TB] FAIL hs_press_pending: got %b/%b want 1000", p0, p2); end
    checks++; if (d0 !== 8'd0 || d2 !== 8'd0) begin failures++; $display("[TB] FAIL hs_press_drop: got %0d/%0d want 0", d0, d2); end
    checks++; if (v0 !== 1'b0) begin failures++; $display("[TB] FAIL hs_press_bubble: got %b want 0", v0); end
    stepCycle();
    checks++; if (v0 !== 1'b1 || i0 !== 2'd3) begin failures++; $display("[TB] FAIL hs_press_reissue: got valid=%b idx=%0d want 1/3", v0, i0); end
  endtask

  task automatic test_async_reset();
    doReset();
    accReady = 1'b0;
    b1 = 1'b1; stepCycle(); stepCycle();
    b1 = 1'b0; stepCycle(); stepCycle();
    b1 = 1'b1; stepCycle(); stepCycle();
    b1 = 1'b0;
    for (int c = 0; c < 4; c++) stepCycle();
    checks++; if (d0 !== 8'd1 || v0 !== 1'b1) begin failures++; $display("[TB] FAIL areset_setup: got drop=%0d valid=%b want 1/1", d0, v0); end
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checks++; if (v0 !== 1'b0 || v2 !== 1'b0) begin failures++; $display("[TB] FAIL areset_valid: got %b/%b want 0", v0, v2); end
    checks++; if (p0 !== 4'b0 || d0 !== 8'd0 || bz0 !== 1'b0) begin failures++; $display("[TB] FAIL areset_regs: got pend=%b drop=%0d busy=%b want 0", p0, d0, bz0); end
    stepCycle();
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic       oV, oB;
    logic [1:0] oI;
    logic [3:0] oP;
    logic [7:0] oD;
    doReset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) b1 = ~b1;
      if ($urandom_range(3) == 0) b2 = ~b2;
      if ($urandom_range(3) == 0) b3 = ~b3;
      if ($urandom_range(3) == 0) b4 = ~b4;
      tick     = ($urandom_range(4) == 0);
      accReady = ($urandom_range(1) == 0);
      stepCycle();
      for (int k = 0; k < 2; k++) begin
        oV = (k == 0) ? v0 : v2;
        oB = (k == 0) ? bz0 : bz2;
        oI = (k == 0) ? i0 : i2;
        oP = (k == 0) ? p0 : p2;
        oD = (k == 0) ? d0 : d2;
        checks++; if (oV !== mFlight[k]) begin failures++; $display("[TB] FAIL rand_valid k=%0d c=%0d: got %b want %b", k, c, oV, mFlight[k]); end
        checks++; if (oB !== (mFlight[k] || mWait[k] > 0)) begin failures++; $display("[TB] FAIL rand_busy k=%0d c=%0d: got %b", k, c, oB); end
        checks++; if (oP !== mPend[k]) begin failures++; $display("[TB] FAIL rand_pending k=%0d c=%0d: got %b want %b", k, c, oP, mPend[k]); end
        checks++; if (oD !== 8'(mDrop[k])) begin failures++; $display("[TB] FAIL rand_drop k=%0d c=%0d: got %0d want %0d", k, c, oD, mDrop[k]); end
        if (mFlight[k]) begin
          checks++; if (oI !== 2'(mSlot[k])) begin failures++; $display("[TB] FAIL rand_idx k=%0d c=%0d: got %0d want %0d", k, c, oI, mSlot[k]); end
        end
      end
    end
    b1 = 1'b0; b2 = 1'b0; b3 = 1'b0; b4 = 1'b0; tick = 1'b0; accReady = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    b1 = 1'b0; b2 = 1'b0; b3 = 1'b0; b4 = 1'b0; tick = 1'b0; accReady = 1'b0;
    modelReset();
    #1 rst = 1'b0;
    test_reset();
    test_single_press();
    test_round_robin();
    test_backpressure();
    test_holdoff();
    test_drops();
    test_press_on_handshake();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
